dram_dma: RTL and testbench

- Block-copy / block-fill DMA engine, a third DRAM requester beside video fetch and Z80.
- Configured by zports registers (source, destination, length, mode). Sequences word-wide DRAM transactions through a dedicated arbiter port with a single-transaction handshake.
- Uses an internal burst buffer: reads up to BURST words, then writes them back, so arbiter slots are grouped.
- Raises busy while running and a one-cycle done pulse that zports and zint can use.

---
 rtl/dram_dma.sv | 175 +++++++++++++++++
 tb/tb_dram_dma.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_dma.sv
// Block-copy / block-fill DMA engine: a third DRAM requester with a burst buffer so that
// reads and writes are grouped into runs of up to BURST words.
module dram_dma #(
  parameter int unsigned BURST = 4,
  parameter int unsigned LEN_W = 10
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             fill,
  input  logic [20:0]      src_addr,
  input  logic [20:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      fill_data,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] remain,
  output logic             dma_req,
  output logic             dma_rnw,
  output logic [20:0]      dma_addr,
  output logic [15:0]      dma_wrdata,
  output logic [1:0]       dma_bsel,
  input  logic             dma_next,
  input  logic             dma_strobe,
  input  logic [15:0]      dma_rddata
);

  localparam int unsigned PW = $clog2(BURST);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWrReq, StAbortWait} state_e;

  state_e           state_q, state_d;
  logic [20:0]      src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic             fill_q, fill_d;
  logic [15:0]      pat_q, pat_d;
  logic [CW-1:0]    chunk_q, chunk_d, wptr_q, wptr_d, rptr_q, rptr_d;
  logic             done_q, done_d;
  logic             mem_we;
  logic [15:0]      mem_q [BURST];

  function automatic logic [CW-1:0] chunk_of(input logic [LEN_W-1:0] n);
    if (int'(n) > int'(BURST)) chunk_of = CW'(BURST);
    else                       chunk_of = CW'(n);
  endfunction

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    remain_d = remain_q;
    fill_d   = fill_q;
    pat_d    = pat_q;
    chunk_d  = chunk_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    done_d   = 1'b0;
    mem_we   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // start takes priority over abort; abort alone is a no-op here
        if (start) begin
          src_d    = src_addr;
          dst_d    = dst_addr;
          remain_d = len;
          fill_d   = fill;
          pat_d    = fill_data;
          wptr_d   = '0;
          rptr_d   = '0;
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            chunk_d = chunk_of(len);
            state_d = fill ? StWrReq : StRdReq;
          end
        end
      end
      StRdReq: begin
        if (dma_next) begin
          src_d   = src_q + 21'd1;
          state_d = abort ? StAbortWait : StRdWait;
        end else if (abort) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StRdWait: begin
        if (dma_strobe) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + CW'(1);
          if (abort) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (wptr_q + CW'(1) < chunk_q) begin
            state_d = StRdReq;
          end else begin
            state_d = StWrReq;
            rptr_d  = '0;
          end
        end else if (abort) begin
          state_d = StAbortWait;
        end
      end
      StWrReq: begin
        if (dma_next) begin
          dst_d    = dst_q + 21'd1;
          remain_d = remain_q - LEN_W'(1);
          rptr_d   = rptr_q + CW'(1);
          if (remain_q == LEN_W'(1) || abort) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (rptr_q + CW'(1) == chunk_q) begin
            chunk_d = chunk_of(remain_q - LEN_W'(1));
            rptr_d  = '0;
            wptr_d  = '0;
            state_d = fill_q ? StWrReq : StRdReq;
          end
        end else if (abort) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StAbortWait: begin
        if (dma_strobe) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q  <= StIdle;
      src_q    <= '0;
      dst_q    <= '0;
      remain_q <= '0;
      fill_q   <= 1'b0;
      pat_q    <= '0;
      chunk_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      remain_q <= remain_d;
      fill_q   <= fill_d;
      pat_q    <= pat_d;
      chunk_q  <= chunk_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      done_q   <= done_d;
    end
  end

  // Buffer contents need no reset: every slot is written before it is read.
  always_ff @(posedge fclk) begin
    if (mem_we) mem_q[wptr_q[PW-1:0]] <= dma_rddata;
  end

  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign remain     = remain_q;
  assign dma_req    = (state_q == StRdReq) || (state_q == StWrReq);
  assign dma_rnw    = (state_q == StRdReq);
  assign dma_addr   = (state_q == StRdReq) ? src_q : (state_q == StWrReq) ? dst_q : 21'd0;
  assign dma_wrdata = (state_q != StWrReq) ? 16'd0 : fill_q ? pat_q : mem_q[rptr_q[PW-1:0]];
  assign dma_bsel   = 2'b11;

endmodule

// File: tb/tb_dram_dma.sv
// Directed bench for dram_dma: a small arbiter/DRAM responder logs granted transactions,
// and one linear initial block drives scenarios and checks against hand-derived values.
module tb_dram_dma;

  logic        fclk, rst, start, abort, fill;
  logic [20:0] src_addr, dst_addr;
  logic [9:0]  len;
  logic [15:0] fill_data;
  logic        busy, done;
  logic [9:0]  remain;
  logic        dma_req, dma_rnw;
  logic [20:0] dma_addr;
  logic [15:0] dma_wrdata;
  logic [1:0]  dma_bsel;
  logic        dma_next, dma_strobe;
  logic [15:0] dma_rddata;

  dram_dma #(.BURST(4), .LEN_W(10)) dut (
    .fclk(fclk), .rst(rst), .start(start), .abort(abort), .fill(fill),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
    .busy(busy), .done(done), .remain(remain),
    .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr), .dma_wrdata(dma_wrdata),
    .dma_bsel(dma_bsel), .dma_next(dma_next), .dma_strobe(dma_strobe), .dma_rddata(dma_rddata)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  typedef struct packed {
    logic        rnw;
    logic [20:0] addr;
    logic [15:0] data;
  } txn_t;

  txn_t        txq[$];
  int          n_rd, n_wr, n_done, n_req_cycles, gcnt, rd_pend;
  logic        busy_seen, spurious_next;
  logic [20:0] rd_addr;
  int          n_asserts, n_fail;

  function automatic logic [15:0] rd_model(input logic [20:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  // Arbiter + DRAM: grant after two waiting cycles, read data three cycles after grant.
  always @(negedge fclk) begin
    dma_next   = 1'b0;
    dma_strobe = 1'b0;
    if (rst) begin
      rd_pend = 0;
      gcnt    = 0;
    end else begin
      if (rd_pend != 0) begin
        rd_pend = rd_pend - 1;
        if (rd_pend == 0) begin
          dma_strobe = 1'b1;
          dma_rddata = rd_model(rd_addr);
        end
      end
      if (dma_req) begin
        n_req_cycles = n_req_cycles + 1;
        if (gcnt == 2) begin
          dma_next = 1'b1;
          gcnt     = 0;
          txq.push_back({dma_rnw, dma_addr, dma_wrdata});
          if (dma_rnw) begin
            n_rd    = n_rd + 1;
            rd_pend = 3;
            rd_addr = dma_addr;
          end else begin
            n_wr = n_wr + 1;
          end
        end else begin
          gcnt = gcnt + 1;
        end
      end else begin
        gcnt     = 0;
        dma_next = spurious_next;
      end
      if (done) n_done = n_done + 1;
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_txn(input string tag, input int idx, input logic rnw,
                         input logic [20:0] addr, input logic [15:0] data);
    if (idx < txq.size()) begin
      check($sformatf("%s[%0d].rnw", tag, idx), 32'(txq[idx].rnw), 32'(rnw));
      check($sformatf("%s[%0d].addr", tag, idx), 32'(txq[idx].addr), 32'(addr));
      if (!rnw) check($sformatf("%s[%0d].data", tag, idx), 32'(txq[idx].data), 32'(data));
    end else begin
      check($sformatf("%s[%0d].missing", tag, idx), 32'(txq.size()), 32'(idx + 1));
    end
  endtask

  task automatic clear_log();
    txq.delete();
    n_rd = 0; n_wr = 0; n_done = 0; n_req_cycles = 0; busy_seen = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge fclk);
    #2;
  endtask

  task automatic do_start(input logic f, input logic [20:0] s, input logic [20:0] d,
                          input logic [9:0] l, input logic [15:0] fd);
    fill = f; src_addr = s; dst_addr = d; len = l; fill_data = fd;
    start = 1'b1;
    @(posedge fclk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge fclk);
      #2;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, ".done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    n_asserts = 0; n_fail = 0;
    n_rd = 0; n_wr = 0; n_done = 0; n_req_cycles = 0; gcnt = 0; rd_pend = 0;
    busy_seen = 1'b0; spurious_next = 1'b0; rd_addr = '0;
    dma_next = 1'b0; dma_strobe = 1'b0; dma_rddata = '0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; fill = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0; fill_data = '0;

    // Reset state
    cycles(3);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.remain", 32'(remain), 32'd0);
    check("rst.req", 32'(dma_req), 32'd0);
    check("rst.rnw", 32'(dma_rnw), 32'd0);
    check("rst.addr", 32'(dma_addr), 32'd0);
    check("rst.wrdata", 32'(dma_wrdata), 32'd0);
    check("rst.bsel", 32'(dma_bsel), 32'd3);
    rst = 1'b0;
    cycles(2);

    // Copy len=6: two bursts (4 + 2)
    clear_log();
    do_start(1'b0, 21'h00100, 21'h08000, 10'd6, 16'h0000);
    check("copy.busy_after_start", 32'(busy), 32'd1);
    wait_done("copy");
    check("copy.busy_at_done", 32'(busy), 32'd0);
    cycles(4);
    check("copy.ntxn", 32'(txq.size()), 32'd12);
    for (int i = 0; i < 4; i++) chk_txn("copy", i, 1'b1, 21'h00100 + 21'(i), 16'h0);
    for (int i = 0; i < 4; i++)
      chk_txn("copy", 4 + i, 1'b0, 21'h08000 + 21'(i), rd_model(21'h00100 + 21'(i)));
    for (int i = 0; i < 2; i++) chk_txn("copy", 8 + i, 1'b1, 21'h00104 + 21'(i), 16'h0);
    for (int i = 0; i < 2; i++)
      chk_txn("copy", 10 + i, 1'b0, 21'h08004 + 21'(i), rd_model(21'h00104 + 21'(i)));
    check("copy.ndone", 32'(n_done), 32'd1);
    check("copy.remain", 32'(remain), 32'd0);
    check("copy.bsel", 32'(dma_bsel), 32'd3);

    // Fill len=5 across the 21-bit wrap
    clear_log();
    do_start(1'b1, 21'h00000, 21'h1FFFFE, 10'd5, 16'hA55A);
    wait_done("fill");
    cycles(4);
    check("fill.ntxn", 32'(txq.size()), 32'd5);
    chk_txn("fill", 0, 1'b0, 21'h1FFFFE, 16'hA55A);
    chk_txn("fill", 1, 1'b0, 21'h1FFFFF, 16'hA55A);
    chk_txn("fill", 2, 1'b0, 21'h000000, 16'hA55A);
    chk_txn("fill", 3, 1'b0, 21'h000001, 16'hA55A);
    chk_txn("fill", 4, 1'b0, 21'h000002, 16'hA55A);
    check("fill.nreads", 32'(n_rd), 32'd0);
    check("fill.ndone", 32'(n_done), 32'd1);

    // len=0: immediate done, never busy, no requests
    clear_log();
    do_start(1'b0, 21'h00010, 21'h00020, 10'd0, 16'h0);
    check("len0.done", 32'(done), 32'd1);
    check("len0.busy", 32'(busy), 32'd0);
    cycles(1);
    check("len0.done_drop", 32'(done), 32'd0);
    cycles(3);
    check("len0.req_cycles", 32'(n_req_cycles), 32'd0);
    check("len0.busy_seen", 32'(busy_seen), 32'd0);
    check("len0.ndone", 32'(n_done), 32'd1);

    // Abort in RD_WAIT of the second burst
    clear_log();
    do_start(1'b0, 21'h00200, 21'h09000, 10'd8, 16'h0);
    for (int i = 0; i < 1000; i++) begin
      if (n_wr == 4 && n_rd == 5) break;
      cycles(1);
    end
    check("abort.reached_rdwait", 32'(n_rd), 32'd5);
    abort = 1'b1;
    cycles(1);
    abort = 1'b0;
    wait_done("abort");
    cycles(20);
    check("abort.nrd", 32'(n_rd), 32'd5);
    check("abort.nwr", 32'(n_wr), 32'd4);
    check("abort.ndone", 32'(n_done), 32'd1);
    check("abort.remain", 32'(remain), 32'd4);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.strobe_consumed", 32'(rd_pend), 32'd0);

    // start while busy and spurious dma_next with req low
    clear_log();
    spurious_next = 1'b1;
    do_start(1'b0, 21'h00300, 21'h0A000, 10'd3, 16'h0);
    cycles(3);
    do_start(1'b1, 21'h00777, 21'h01234, 10'd9, 16'hFFFF);
    wait_done("busy_start");
    cycles(4);
    spurious_next = 1'b0;
    check("busy_start.ntxn", 32'(txq.size()), 32'd6);
    for (int i = 0; i < 3; i++) chk_txn("busy_start", i, 1'b1, 21'h00300 + 21'(i), 16'h0);
    for (int i = 0; i < 3; i++)
      chk_txn("busy_start", 3 + i, 1'b0, 21'h0A000 + 21'(i), rd_model(21'h00300 + 21'(i)));
    check("busy_start.ndone", 32'(n_done), 32'd1);
    check("busy_start.remain", 32'(remain), 32'd0);

    // Reset mid WR_REQ, then a clean copy
    clear_log();
    do_start(1'b1, 21'h00000, 21'h00100, 10'd10, 16'h1111);
    for (int i = 0; i < 1000; i++) begin
      if (n_wr == 2) break;
      cycles(1);
    end
    check("rstmid.reached_wr", 32'(n_wr), 32'd2);
    rst = 1'b1;
    cycles(1);
    check("rstmid.req", 32'(dma_req), 32'd0);
    check("rstmid.busy", 32'(busy), 32'd0);
    check("rstmid.remain", 32'(remain), 32'd0);
    check("rstmid.done", 32'(done), 32'd0);
    rst = 1'b0;
    cycles(2);
    clear_log();
    do_start(1'b0, 21'h00040, 21'h00050, 10'd2, 16'h0);
    wait_done("post_rst");
    cycles(4);
    check("post_rst.ntxn", 32'(txq.size()), 32'd4);
    chk_txn("post_rst", 0, 1'b1, 21'h00040, 16'h0);
    chk_txn("post_rst", 1, 1'b1, 21'h00041, 16'h0);
    chk_txn("post_rst", 2, 1'b0, 21'h00050, rd_model(21'h00040));
    chk_txn("post_rst", 3, 1'b0, 21'h00051, rd_model(21'h00041));
    check("post_rst.remain", 32'(remain), 32'd0);
    check("post_rst.ndone", 32'(n_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
